slave_in_port: RTL and testbench
================================

SLAVE_IN_PORT -- requirements
Module: slave_in_port

Interface
REQ-001 The module SHALL have parameter ADDR_LEN, default 12, meaning the number of serial address bits per transaction.
REQ-002 The module SHALL have parameter DATA_LEN, default 8, meaning the number of serial write-data bits and the width of memory data.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port select, input, 1 bit: from the address decoder, high when this slave is the target.
REQ-006 The module SHALL have port master_valid, input, 1 bit: the master is driving a transaction.
REQ-007 The module SHALL have ports write_en and read_en, input, 1 bit each: the transaction type, sampled at handshake.
REQ-008 The module SHALL have ports rx_address and rx_data, input, 1 bit each: the serial address and data lines, LSB first.
REQ-009 The module SHALL have port slave_ready, output, 1 bit: the slave accepts a handshake.
REQ-010 The module SHALL have port mem_address, output, ADDR_LEN bits: the deserialised address.
REQ-011 The module SHALL have port mem_wdata, output, DATA_LEN bits: the deserialised write data.
REQ-012 The module SHALL have ports mem_write and mem_read, output, 1 bit each: memory request strobes.
REQ-013 The module SHALL have port mem_ack, input, 1 bit: memory completed the request.
REQ-014 The module SHALL have port mem_rdata, input, DATA_LEN bits: memory read data, valid while mem_ack=1.
REQ-015 The module SHALL have port read_data, output, DATA_LEN bits: captured read data, held until the next read.
REQ-016 The module SHALL have port rx_done, output, 1 bit: one-cycle pulse on transaction completion.

Function
REQ-017 The state machine SHALL have the states IDLE, RECEIVE, MEM_WRITE, MEM_READ and DONE; all outputs SHALL be registered.
REQ-018 A handshake SHALL occur on an edge in IDLE with select=1, master_valid=1, slave_ready=1 and exactly one of write_en/read_en high; both high or both low SHALL leave the state IDLE.
REQ-019 On the handshake edge the module SHALL capture bit 0 of address (and of data if write), latch the transaction type, set count=1, clear slave_ready and enter RECEIVE.
REQ-020 In RECEIVE, each edge SHALL capture rx_address into bit count if count<ADDR_LEN, and rx_data into bit count if write and count<DATA_LEN; count SHALL then increment.
REQ-021 The bit total N SHALL be max(ADDR_LEN,DATA_LEN) for a write and ADDR_LEN for a read; on the edge capturing bit N-1 the module SHALL enter MEM_WRITE with mem_write=1, or MEM_READ with mem_read=1.
REQ-022 The state SHALL remain MEM_WRITE/MEM_READ with the strobe held high until mem_ack=1 is sampled; on that edge the strobe SHALL clear, rx_done SHALL be set to 1 and the state SHALL go to DONE; in MEM_READ, read_data SHALL load mem_rdata on the same edge.
REQ-023 DONE SHALL last one cycle, then clear rx_done, set slave_ready=1 and return to IDLE.
REQ-024 If master_valid=0 is sampled in RECEIVE, the module SHALL abort to IDLE with slave_ready=1, no memory strobe and no rx_done; mem_address/mem_wdata keep partial contents.
REQ-025 Bits of mem_wdata at or above DATA_LEN on a read SHALL retain their previous values; mem_address/mem_wdata SHALL be stable while a strobe is high.
REQ-026 mem_ack sampled outside the MEM states SHALL be ignored; select/master_valid outside IDLE/RECEIVE SHALL be ignored.
REQ-027 count SHALL be wide enough for max(ADDR_LEN,DATA_LEN) and SHALL not wrap.

Reset
REQ-028 On reset=1, asynchronously: state=IDLE, count=0, slave_ready=1, mem_write=0, mem_read=0, rx_done=0, mem_address=0, mem_wdata=0, read_data=0.
REQ-029 Reset asserted mid-RECEIVE or mid-MEM SHALL drop the strobes immediately and discard the transaction.

Verification
REQ-030 Write of addr 0x5A3 with data 0xC7, defaults, mem_ack tied high: handshake at edge E0, bits E0..E11 -> mem_write high after E11, mem_address=0x5A3, mem_wdata=0xC7, rx_done high after E12, slave_ready high after E13.
REQ-031 Read of addr 0x0F0 with mem_ack delayed 3 cycles and mem_rdata=0x3C -> mem_read held 4 cycles, read_data=0x3C, one rx_done pulse.
REQ-032 write_en=read_en=1 with master_valid=1 and select=1 -> slave_ready stays 1, no state change, no strobes.
REQ-033 master_valid dropped after 5 bits -> return to IDLE, slave_ready=1, no mem_write, no rx_done.
REQ-034 reset pulsed while mem_write=1 -> mem_write=0 immediately, all outputs at reset values.
REQ-035 select=0 with a valid handshake -> no capture, slave_ready stays 1.

Source files
------------

// File: rtl/slave_in_port.sv
// Serial-in slave port: deserialises an LSB-first address (and write data),
// issues a single memory request, and signals completion with rx_done.
module slave_in_port #(
  parameter int ADDR_LEN = 12,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                select,
  input  logic                master_valid,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic [ADDR_LEN-1:0] mem_address,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_write,
  output logic                mem_read,
  input  logic                mem_ack,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic [DATA_LEN-1:0] read_data,
  output logic                rx_done
);

  localparam int MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(ADDR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    MEM_WRITE,
    MEM_READ,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_write;
  logic             handshake;
  logic [CNT_W-1:0] last_bit;

  // Exactly one of write_en/read_en must be set for the slave to accept.
  assign handshake = select & master_valid & slave_ready & (write_en ^ read_en);
  assign last_bit  = is_write ? LAST_WR : LAST_RD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      is_write    <= 1'b0;
      slave_ready <= 1'b1;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      rx_done     <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      read_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            mem_address[0] <= rx_address;
            if (write_en) mem_wdata[0] <= rx_data;
            is_write    <= write_en;
            count       <= CNT_W'(1);
            slave_ready <= 1'b0;
            // A one-bit transaction completes on the handshake edge itself.
            if ((write_en ? LAST_WR : LAST_RD) == '0) begin
              state     <= write_en ? MEM_WRITE : MEM_READ;
              mem_write <= write_en;
              mem_read  <= ~write_en;
            end else begin
              state <= RECEIVE;
            end
          end
        end
        RECEIVE: begin
          if (!master_valid) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
            count       <= '0;
          end else begin
            for (int i = 0; i < ADDR_LEN; i++)
              if (count == CNT_W'(i)) mem_address[i] <= rx_address;
            if (is_write)
              for (int i = 0; i < DATA_LEN; i++)
                if (count == CNT_W'(i)) mem_wdata[i] <= rx_data;
            if (count == last_bit) begin
              if (is_write) begin
                state     <= MEM_WRITE;
                mem_write <= 1'b1;
              end else begin
                state    <= MEM_READ;
                mem_read <= 1'b1;
              end
            end
            count <= count + 1'b1;
          end
        end
        MEM_WRITE: begin
          if (mem_ack) begin
            mem_write <= 1'b0;
            rx_done   <= 1'b1;
            state     <= DONE;
          end
        end
        MEM_READ: begin
          if (mem_ack) begin
            mem_read  <= 1'b0;
            read_data <= mem_rdata;
            rx_done   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          rx_done     <= 1'b0;
          slave_ready <= 1'b1;
          count       <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Randomised bench for slave_in_port against a transaction-level model of
// the expected address/data/read-data registers.
module tb_slave_in_port;
  localparam int AL = 12;
  localparam int DL = 8;
  localparam int NW = (AL > DL) ? AL : DL;

  logic          clk = 1'b0;
  logic          reset, select, master_valid, write_en, read_en;
  logic          rx_address, rx_data, mem_ack;
  logic [DL-1:0] mem_rdata;
  logic          slave_ready, mem_write, mem_read, rx_done;
  logic [AL-1:0] mem_address;
  logic [DL-1:0] mem_wdata, read_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  slave_in_port #(.ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clk(clk), .reset(reset), .select(select), .master_valid(master_valid),
    .write_en(write_en), .read_en(read_en), .rx_address(rx_address),
    .rx_data(rx_data), .slave_ready(slave_ready), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .read_data(read_data),
    .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Replace the low k bits of old with those of nw.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input int k);
    logic [31:0] mask;
    mask = (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, slave_ready, 1);
    chk({tag, "_wr"}, mem_write, 0);
    chk({tag, "_rd"}, mem_read, 0);
    chk({tag, "_done"}, rx_done, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, read_data, 0);
  endtask

  task automatic idle_inputs();
    select = 0; master_valid = 0; write_en = 0; read_en = 0;
    rx_address = 0; rx_data = 0; mem_ack = 0;
  endtask

  // Drive inputs that must not start a transaction; nothing may change.
  task automatic idle_probe(input string tag, input bit sel, input bit we, input bit re);
    select = sel; master_valid = 1; write_en = we; read_en = re;
    for (int c = 0; c < 3; c++) begin
      rx_address = 1'($urandom); rx_data = 1'($urandom); mem_ack = 1'($urandom);
      tick();
      chk({tag, "_ready"}, slave_ready, 1);
      chk({tag, "_strobe"}, {mem_write, mem_read}, 0);
      chk({tag, "_done"}, rx_done, 0);
      chk({tag, "_addr"}, mem_address, exp_addr);
      chk({tag, "_wdata"}, mem_wdata, exp_wdata);
    end
    idle_inputs();
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [DL-1:0] rd, input int ack_dly, input int abort_at,
                         input bit rst_in_mem);
    int n;
    n = wr ? NW : AL;
    chk("pre_ready", slave_ready, 1);
    select = 1; master_valid = 1; write_en = wr; read_en = !wr;
    rx_address = addr[0]; rx_data = data[0]; mem_ack = 1'($urandom);
    tick();
    chk("hs_ready_low", slave_ready, 0);
    write_en = 1'($urandom); read_en = 1'($urandom);
    for (int b = 1; b < n; b++) begin
      if (b == abort_at) begin
        master_valid = 0;
        tick();
        exp_addr = merge(exp_addr, addr, b);
        if (wr) exp_wdata = merge(exp_wdata, data, (b < DL) ? b : DL);
        chk("abort_ready", slave_ready, 1);
        chk("abort_strobe", {mem_write, mem_read}, 0);
        chk("abort_done", rx_done, 0);
        chk("abort_addr", mem_address, exp_addr);
        chk("abort_wdata", mem_wdata, exp_wdata);
        idle_inputs();
        tick();
        chk("abort_idle_done", rx_done, 0);
        chk("abort_idle_strobe", {mem_write, mem_read}, 0);
        return;
      end
      rx_address = (b < AL) ? 1'(addr >> b) : 1'($urandom);
      rx_data    = (wr && b < DL) ? 1'(data >> b) : 1'($urandom);
      mem_ack    = 1'($urandom);
      tick();
      if (b < n - 1) chk("rx_no_strobe", {mem_write, mem_read}, 0);
    end
    exp_addr = addr & ((32'd1 << AL) - 1);
    if (wr) exp_wdata = data & ((32'd1 << DL) - 1);
    chk("strobe_on", {mem_write, mem_read}, wr ? 32'd2 : 32'd1);
    chk("strobe_addr", mem_address, exp_addr);
    chk("strobe_wdata", mem_wdata, exp_wdata);
    chk("strobe_ready", slave_ready, 0);
    if (rst_in_mem) begin
      #1 reset = 1;
      #1;
      exp_addr = 0; exp_wdata = 0; exp_rdata = 0;
      check_reset_vals("rst_mem");
      idle_inputs();
      tick();
      reset = 0;
      tick();
      check_reset_vals("rst_after");
      return;
    end
    select = 1'($urandom); master_valid = 1'($urandom);
    write_en = 1'($urandom); read_en = 1'($urandom); mem_ack = 0;
    for (int d = 0; d < ack_dly; d++) begin
      mem_rdata = DL'($urandom);
      tick();
      chk("wait_strobe", {mem_write, mem_read}, wr ? 32'd2 : 32'd1);
      chk("wait_done", rx_done, 0);
      chk("wait_addr", mem_address, exp_addr);
      chk("wait_wdata", mem_wdata, exp_wdata);
    end
    mem_ack = 1; mem_rdata = rd;
    tick();
    if (!wr) exp_rdata = rd;
    chk("ack_strobe_off", {mem_write, mem_read}, 0);
    chk("ack_done", rx_done, 1);
    chk("ack_rdata", read_data, exp_rdata);
    chk("ack_ready", slave_ready, 0);
    mem_ack = 1'($urandom); mem_rdata = DL'($urandom);
    tick();
    chk("fin_done", rx_done, 0);
    chk("fin_ready", slave_ready, 1);
    chk("fin_rdata", read_data, exp_rdata);
    chk("fin_strobe", {mem_write, mem_read}, 0);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mem_rdata = 0;
    exp_addr = 0; exp_wdata = 0; exp_rdata = 0;
    reset = 1;
    #2;
    check_reset_vals("reset");
    tick();
    tick();
    reset = 0;
    tick();
    check_reset_vals("post_reset");

    run_txn(1, 32'h5A3, 32'hC7, 8'h00, 0, -1, 0);
    run_txn(0, 32'h0F0, 32'h00, 8'h3C, 3, -1, 0);
    idle_probe("both_en", 1, 1, 1);
    idle_probe("none_en", 1, 0, 0);
    run_txn(1, 32'hABC, 32'h5E, 8'h00, 0, 5, 0);
    run_txn(1, 32'h123, 32'h99, 8'h00, 0, -1, 1);
    idle_probe("no_select", 0, 1, 0);
    idle_probe("no_select_rd", 0, 0, 1);

    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)
        idle_probe("rand_probe", 1'($urandom), 1, 1);
      else
        run_txn(1'($urandom), $urandom, $urandom, DL'($urandom),
                int'($urandom_range(0, 4)),
                (kind == 1) ? int'($urandom_range(1, AL - 1)) : -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
